// File: rtl/bus_timer.sv
`default_nettype none
// ============================================================================
// Module      : bus_timer
// Description : Memory-mapped up-counting timer with a 16-bit prescaler,
//               auto-reload / one-shot modes and a maskable update interrupt.
//
//   Register map (byte offsets from BASE_ADDR, word access only):
//     0x00 CTRL   [0] EN, [1] OPM (1 = one-shot), [2] IE
//     0x04 PSC    [15:0] prescale value (tick every PSC+1 cycles)
//     0x08 CNT    [31:0] counter
//     0x0C ARR    [31:0] reload / compare value
//     0x10 STATUS [0] UIF, write 1 to clear
//
//   Ports:
//     clk    : single clock, rising edge
//     reset  : synchronous active-high reset
//     we     : bus write strobe
//     addr   : bus byte address, block decoded on addr[31:8]
//     wData  : bus write data
//     func3  : store width, only word (3'b010) stores are accepted
//     rData  : combinational read data for addr
//     irq    : interrupt request, UIF & IE
//
// Revision    : 1.0 - initial release
// ============================================================================
module bus_timer #(
    parameter logic [31:0] BASE_ADDR = 32'h1000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wData,
    input  logic [2:0]  func3,
    output logic [31:0] rData,
    output logic        irq
);

    localparam logic [7:0] c_OFF_CTRL   = 8'h00;
    localparam logic [7:0] c_OFF_PSC    = 8'h04;
    localparam logic [7:0] c_OFF_CNT    = 8'h08;
    localparam logic [7:0] c_OFF_ARR    = 8'h0C;
    localparam logic [7:0] c_OFF_STATUS = 8'h10;
    localparam logic [2:0] c_FUNC3_WORD = 3'b010;

    // Registered state
    logic        r_en;
    logic        r_opm;
    logic        r_ie;
    logic        r_uif;
    logic [15:0] r_psc;
    logic [15:0] r_preCnt;
    logic [31:0] r_cnt;
    logic [31:0] r_arr;

    // Decode and event wires
    logic        w_sel;
    logic        w_wrOk;
    logic        w_wrCtrl;
    logic        w_wrPsc;
    logic        w_wrCnt;
    logic        w_wrArr;
    logic        w_wrStatus;
    logic        w_tick;
    logic        w_update;

    assign w_sel      = (addr[31:8] == BASE_ADDR[31:8]);
    assign w_wrOk     = we && w_sel && (func3 == c_FUNC3_WORD) && (addr[1:0] == 2'b00);
    assign w_wrCtrl   = w_wrOk && (addr[7:0] == c_OFF_CTRL);
    assign w_wrPsc    = w_wrOk && (addr[7:0] == c_OFF_PSC);
    assign w_wrCnt    = w_wrOk && (addr[7:0] == c_OFF_CNT);
    assign w_wrArr    = w_wrOk && (addr[7:0] == c_OFF_ARR);
    assign w_wrStatus = w_wrOk && (addr[7:0] == c_OFF_STATUS);

    // Tick on the cycle the prescaler reaches PSC; the update event is a
    // tick that finds CNT at the compare value. A CNT above ARR simply runs
    // on through the natural 32-bit wrap without matching.
    assign w_tick   = r_en && (r_preCnt == r_psc);
    assign w_update = w_tick && (r_cnt == r_arr);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_en     <= 1'b0;
            r_opm    <= 1'b0;
            r_ie     <= 1'b0;
            r_uif    <= 1'b0;
            r_psc    <= 16'd0;
            r_preCnt <= 16'd0;
            r_cnt    <= 32'd0;
            r_arr    <= 32'hFFFF_FFFF;
        end else begin
            // Control: a bus write beats the one-shot self-disable
            if (w_wrCtrl) begin
                r_en  <= wData[0];
                r_opm <= wData[1];
                r_ie  <= wData[2];
            end else if (w_update && r_opm) begin
                r_en <= 1'b0;
            end

            // Prescaler: writing PSC restarts the prescale phase
            if (w_wrPsc) begin
                r_psc    <= wData[15:0];
                r_preCnt <= 16'd0;
            end else if (r_en) begin
                r_preCnt <= w_tick ? 16'd0 : r_preCnt + 16'd1;
            end

            // Counter: a bus write beats both increment and reload
            if (w_wrCnt) begin
                r_cnt <= wData;
            end else if (w_tick) begin
                r_cnt <= w_update ? 32'd0 : r_cnt + 32'd1;
            end

            if (w_wrArr) begin
                r_arr <= wData;
            end

            // Update flag: a same-cycle event wins over the W1C
            if (w_update) begin
                r_uif <= 1'b1;
            end else if (w_wrStatus && wData[0]) begin
                r_uif <= 1'b0;
            end
        end
    end

    always_comb begin
        rData = 32'd0;
        if (w_sel) begin
            case (addr[7:0])
                c_OFF_CTRL:   rData = {29'd0, r_ie, r_opm, r_en};
                c_OFF_PSC:    rData = {16'd0, r_psc};
                c_OFF_CNT:    rData = r_cnt;
                c_OFF_ARR:    rData = r_arr;
                c_OFF_STATUS: rData = {31'd0, r_uif};
                default:      rData = 32'd0;
            endcase
        end
    end

    assign irq = r_uif & r_ie;

endmodule
`default_nettype wire

// File: doc/bus_timer.md
BUS_TIMER -- requirements
Module: bus_timer

Interface
REQ-001 Parameter BASE_ADDR, default 32'h1000_0000, SHALL set the block base address; the block SHALL be selected when addr[31:8] == BASE_ADDR[31:8].
REQ-002 Port clk, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port reset, input, 1, SHALL be a synchronous, active-high reset.
REQ-004 Port we, input, 1, SHALL be the bus write strobe, sampled at the clk rising edge.
REQ-005 Port addr, input, 32, SHALL be the bus byte address; register offset is addr[7:0].
REQ-006 Port wData, input, 32, SHALL carry the bus write data.
REQ-007 Port func3, input, 3, SHALL carry the store width; only 3'b010 (word) writes take effect.
REQ-008 Port rData, output, 32, SHALL return the read data combinationally from addr.
REQ-009 Port irq, output, 1, SHALL be the interrupt request, equal to STATUS.UIF & CTRL.IE.

Function
REQ-010 Register map SHALL be: 0x00 CTRL, 0x04 PSC, 0x08 CNT, 0x0C ARR, 0x10 STATUS.
REQ-011 CTRL SHALL hold bit0 EN, bit1 OPM (0 = periodic, 1 = one-shot) and bit2 IE; bits 31:3 SHALL read 0.
REQ-012 PSC SHALL hold a 16-bit prescale value; bits 31:16 SHALL read 0.
REQ-013 CNT SHALL be the 32-bit counter; ARR SHALL be the 32-bit reload/compare value.
REQ-014 STATUS SHALL hold bit0 UIF; writing 1 to bit0 SHALL clear UIF, and writing 0 SHALL have no effect.
REQ-015 A read of an unmapped offset, or with the block not selected, SHALL return 32'h0.
REQ-016 A write SHALL take effect only when we=1, the block is selected, func3=3'b010 and addr[1:0]=2'b00; any other write SHALL be ignored.
REQ-017 While EN=1, an internal 16-bit prescale counter SHALL increment every clk; when it equals PSC it SHALL return to 0 and raise a one-cycle tick.
REQ-018 While EN=0, the prescale counter and CNT SHALL hold their values.
REQ-019 On a tick with CNT != ARR, CNT SHALL increment by 1.
REQ-020 On a tick with CNT == ARR (update event), the following SHALL happen in the same edge: CNT SHALL become 0 and UIF SHALL become 1; if OPM=1, EN SHALL also become 0.
REQ-021 Update event period SHALL be (PSC+1)*(ARR+1) clk cycles; PSC=0 SHALL tick every cycle; ARR=0 SHALL give an update on every tick.
REQ-022 A write to PSC SHALL also clear the prescale counter to 0.
REQ-023 A bus write to CNT SHALL override a same-cycle tick increment or reload.
REQ-024 A bus write to CTRL SHALL override a same-cycle one-shot EN clear.
REQ-025 If a STATUS W1C and an update event occur in the same cycle, the update SHALL win and UIF SHALL be 1 afterwards.
REQ-026 A write to ARR with CNT > new ARR SHALL let CNT count up to 32'hFFFF_FFFF, wrap to 0 with no update event, and continue to the new ARR.
REQ-027 irq SHALL be combinational from registered UIF and IE, with no extra latency.

Reset
REQ-028 With reset=1 at a clk edge, the block SHALL set CTRL=0, PSC=0, the prescale counter to 0, CNT=0, ARR=32'hFFFF_FFFF and UIF=0, so irq=0.
REQ-029 Reset SHALL override any same-cycle bus write or tick, including in the middle of a count.
REQ-030 rData SHALL reflect the reset register values in the cycle after reset deasserts.

Verification
REQ-031 Periodic mode: PSC=1, ARR=3, CTRL=3'b101 -> CNT sequence 0,0,1,1,2,2,3,3,0; UIF and irq rise 8 cycles after EN is set; the pattern repeats every 8 cycles.
REQ-032 One-shot mode: PSC=0, ARR=2, CTRL=3'b011 -> update after 3 cycles; EN reads 0 afterwards; CNT holds 0; irq stays 0 because IE=0.
REQ-033 Collisions: W1C to STATUS in the update cycle -> UIF=1; CNT write 32'h10 in a tick cycle -> CNT=32'h10.
REQ-034 Width filter: byte store (func3=3'b000) of 32'hFF to ARR -> ARR unchanged; read of offset 0x14 -> 32'h0; read at BASE_ADDR+0x100 -> 32'h0.
REQ-035 Reset mid-count: assert reset while CNT=5 and EN=1 -> next cycle CNT=0, EN=0, ARR=32'hFFFF_FFFF, irq=0.
REQ-036 ARR shrink: with CNT=10, write ARR=4 -> CNT passes 32'hFFFF_FFFF, wraps to 0 with UIF still 0, and the update occurs when CNT reaches 4.
